fsm_reinject_queue: RTL

FSM_REINJECT_QUEUE -- requirements
Module: fsm_reinject_queue

---
 rtl/fsm_reinject_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/fsm_reinject_queue.sv
// Show-ahead reinjection queue between the flow FSM and the merger.
// Holds DEPTH entries; ready, empty and occupancy come straight from registered state.

package fsm_reinject_queue_pkg;

    typedef struct packed {
        logic [31:0] tcp_hdr;
        logic [7:0]  flowid;
        logic        payload_val;
        logic [63:0] payload_entry;
    } fsm_reinject_queue_struct;

endpackage

module fsm_reinject_queue
    import fsm_reinject_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fsm_reinject_q_enq_req_val,
    input  fsm_reinject_queue_struct fsm_reinject_q_enq_req_data,
    output logic                     fsm_reinject_q_enq_req_rdy,
    input  logic                     merger_fsm_reinject_q_deq_req_val,
    output fsm_reinject_queue_struct fsm_reinject_q_merger_deq_resp_data,
    output logic                     fsm_reinject_q_merger_empty,
    output logic [PTR_W:0]           fsm_reinject_q_occupancy,
    output logic                     fsm_reinject_q_overflow_err,
    output logic                     fsm_reinject_q_underflow_err
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fsm_reinject_queue_struct storage [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic             overflow_err;
    logic             underflow_err;

    logic             full;
    logic             empty;
    logic             enq_fire;
    logic             deq_fire;

    // Status decoded from the counter only, so ready never depends on this cycle's dequeue.
    assign full     = (occupancy == FULL_CNT);
    assign empty    = (occupancy == '0);
    assign enq_fire = fsm_reinject_q_enq_req_val & ~full;
    assign deq_fire = merger_fsm_reinject_q_deq_req_val & ~empty;

    assign fsm_reinject_q_enq_req_rdy   = ~full;
    assign fsm_reinject_q_merger_empty  = empty;
    assign fsm_reinject_q_occupancy     = occupancy;
    assign fsm_reinject_q_overflow_err  = overflow_err;
    assign fsm_reinject_q_underflow_err = underflow_err;

    always_comb begin
        fsm_reinject_q_merger_deq_resp_data = '0;
        if (!empty) begin
            fsm_reinject_q_merger_deq_resp_data = storage[rd_ptr];
        end
    end

    // Storage is not cleared by reset; the write is still suppressed in a reset cycle.
    always_ff @(posedge clk) begin
        if (rst_n && enq_fire) begin
            storage[wr_ptr] <= fsm_reinject_q_enq_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   occupancy <= occupancy + (PTR_W + 1)'(1);
                2'b01:   occupancy <= occupancy - (PTR_W + 1)'(1);
                default: occupancy <= occupancy;
            endcase
            if (fsm_reinject_q_enq_req_val && full) begin
                overflow_err <= 1'b1;
            end
            if (merger_fsm_reinject_q_deq_req_val && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
